// File: rtl/call_button_conditioner.sv
// Synchronises, debounces and edge-detects NUM_STATIONS call buttons plus a cancel
// button, then arbitrates the press edges into registered call / cancel pulses.
module call_button_conditioner #(
    parameter int NUM_STATIONS    = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int ID_W           = $clog2(NUM_STATIONS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_STATIONS-1:0] call_btn,
    input  logic                    cancel_btn,
    output logic                    call,
    output logic                    cancel,
    output logic [ID_W-1:0]         call_id
);

    localparam int NIN   = NUM_STATIONS + 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Cancel occupies the top lane so every input shares the same debounce path.
    logic [NIN-1:0]            raw;
    logic [NIN-1:0]            s1_q, s2_q;
    logic [NIN-1:0]            db_q, db_d;
    logic [NIN-1:0]            dbp_q;
    logic [NIN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NIN-1:0]            press;

    logic            call_q, call_d;
    logic            cancel_q, cancel_d;
    logic [ID_W-1:0] call_id_q, call_id_d;
    logic            found;

    assign raw = {cancel_btn, call_btn};

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NIN; i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign press = db_q & ~dbp_q;

    // Cancel beats any station; among stations the lowest index wins, losers are dropped.
    always_comb begin
        call_d    = 1'b0;
        cancel_d  = press[NUM_STATIONS];
        call_id_d = call_id_q;
        found     = 1'b0;
        if (!press[NUM_STATIONS]) begin
            for (int unsigned i = 0; i < NUM_STATIONS; i++) begin
                if (press[i] && !found) begin
                    found     = 1'b1;
                    call_d    = 1'b1;
                    call_id_d = ID_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            dbp_q     <= '0;
            cnt_q     <= '0;
            call_q    <= 1'b0;
            cancel_q  <= 1'b0;
            call_id_q <= '0;
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            db_q      <= db_d;
            dbp_q     <= db_q;
            cnt_q     <= cnt_d;
            call_q    <= call_d;
            cancel_q  <= cancel_d;
            call_id_q <= call_id_d;
        end
    end

    assign call    = call_q;
    assign cancel  = cancel_q;
    assign call_id = call_id_q;

endmodule

// File: doc/call_button_conditioner.md
Name: call_button_conditioner

Overview:
- Front-end stage directly upstream of call_system.
- Takes raw, asynchronous, bouncing call buttons from NUM_STATIONS stations and one cancel button. Synchronises and debounces each button, and detects presses.
- Emits clean single-cycle call / cancel pulses plus the ID of the calling station.
- call and cancel drive call_system's call / cancel inputs directly.

Parameters:
- NUM_STATIONS, 4, number of call-button inputs; legal range 2..16.
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from its debounced state before that state flips; minimum 1.
- ID_W (localparam), $clog2(NUM_STATIONS), width of call_id.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- call_btn  in  NUM_STATIONS  raw station buttons, asynchronous, active-high, may bounce.
- cancel_btn  in  1  raw cancel button, asynchronous, active-high, may bounce.
- call  out  1  one-cycle pulse: a new station press was accepted.
- cancel  out  1  one-cycle pulse: a cancel press was accepted.
- call_id  out  ID_W  index of the station behind the most recent accepted call; held between calls.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - call, cancel and call_id are 0.
  - All synchroniser flops, debounced states and debounce counters are 0.
  - Reset takes effect immediately, with no clock needed.
- Per input (each call_btn bit and cancel_btn), same structure:
  - Two-flop synchroniser s1 -> s2.
  - Debounced state db and counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
  - If s2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any return of s2 to db before the threshold restarts the count from 0. Glitches shorter than DEBOUNCE_CYCLES cycles at s2 are rejected.
- Press edge is db rising (0->1) in a cycle. Release (db 1->0) produces no output.
- Output register stage:
  - Press edges are computed combinationally from db and the registered previous db.
  - call, cancel and call_id are registered.
- Latency: the input is held stable high from the first rising edge that samples it. call / cancel is then high for exactly one cycle, during the cycle after edge number DEBOUNCE_CYCLES+3 (7 for the default). A held button gives exactly one pulse.
- Arbitration, evaluated in the same cycle:
  - Multiple station press edges: the lowest index wins. call=1 and call_id=that index.
  - Losing press edges are discarded, not queued.
  - Cancel press edge together with any station press edge: cancel wins. cancel=1, call=0, call_id unchanged, and the station edge is discarded.
- call and cancel are never high in the same cycle.
- call_id changes only in a cycle where call is asserted.
- Button held through reset: after rst_n deasserts, db=0 and the input is high, so it is debounced and yields one press pulse at the normal latency.
- Reset mid-debounce: the counter is cleared and no pulse is produced from the pre-reset partial count.
- Back-to-back presses are accepted as long as each release and each press individually survives debounce. Minimum press-to-press spacing is 2*DEBOUNCE_CYCLES cycles.
- No combinational path from any input port to any output port.

Test Plan:
All tests use defaults: NUM_STATIONS=4, DEBOUNCE_CYCLES=4, 10 ns clock.
1. Reset: rst_n=0 mid-cycle with call_btn=4'b1111 and cancel_btn=1 -> outputs 0 immediately. Release rst_n with call_btn[2]=1 held and others 0 -> exactly one call pulse with call_id=2, 7 edges later; nothing further for 50 cycles.
2. Clean press: call_btn[1]=1 held 20 cycles, then 0 -> call=1 for one cycle with call_id=1, 7 edges after the first sampling edge. Release gives no pulse; call_id stays 1.
3. Bounce and glitch:
   - call_btn[0] toggles each cycle for 6 cycles, then settles high -> one pulse only, with call_id=0.
   - Separately, a 3-cycle high glitch on call_btn[3] -> no pulse.
4. Simultaneous stations: call_btn[3] and call_btn[1] rise on the same edge -> one call pulse with call_id=1. No later pulse for station 3 while it stays held.
5. Cancel collision: with call_id=1 from a prior call, cancel_btn and call_btn[2] rise on the same edge -> cancel=1 and call=0 in that cycle, call_id stays 1. Check that call and cancel never overlap over a 1000-cycle random-press run.
6. Reset mid-debounce: call_btn[0] rises, rst_n pulsed low 3 cycles later, call_btn[0] dropped before reset release -> no call pulse at all.
